// File: rtl/sys_defs.sv
// sys_defs: shared CDB packet type and tag constants used by the arbiter, RS and ROB
`ifndef XLEN
`define XLEN 32
`endif
package sys_defs;
  localparam int TAG_W = 6;
  localparam logic [TAG_W-1:0] CDB_ZERO_TAG = '0;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [`XLEN-1:0] value;
  } CDB_PACKET;
endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: per-FU result buffer with async active-low reset and synchronous clear
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 38
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push && !clear) mem_d[tail_q] = wdata;
    head_d  = clear ? '0 : head_q + PW'(pop);
    tail_d  = clear ? '0 : tail_q + PW'(push);
    count_d = clear ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  assign rdata = mem_q[head_q];
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers FU results per unit and broadcasts one per cycle on the CDB by round-robin
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = sys_defs::TAG_W,
  localparam int ID_W      = NUM_FU > 1 ? $clog2(NUM_FU) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_FU-1:0]         fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU*`XLEN-1:0]   fu_value,
  output logic [NUM_FU-1:0]         fu_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [`XLEN-1:0]          cdb_value,
  output logic [ID_W-1:0]           cdb_fu_id
);
  import sys_defs::*;
  localparam int EW = TAG_W + `XLEN;
  logic [NUM_FU-1:0] full, empty, push, pop;
  logic [EW-1:0]     head [NUM_FU];
  logic              win_valid;
  logic [ID_W-1:0]   win, rr_ptr_q, rr_ptr_d, fu_id_q, fu_id_d;
  CDB_PACKET         cdb_q, cdb_d;
  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign push[i] = fu_valid[i] && !full[i] && !flush && fu_tag[i*TAG_W +: TAG_W] != CDB_ZERO_TAG;
    assign pop[i]  = win_valid && win == ID_W'(i) && !flush;
    cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata ({fu_tag[i*TAG_W +: TAG_W], fu_value[i*`XLEN +: `XLEN]}),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end
  // descending scan so the candidate closest to rr_ptr is the last one assigned
  always_comb begin
    int k;
    win_valid = 1'b0;
    win       = '0;
    for (int j = NUM_FU - 1; j >= 0; j--) begin
      k = (int'(rr_ptr_q) + j) % NUM_FU;
      if (!empty[k]) begin
        win_valid = 1'b1;
        win       = ID_W'(k);
      end
    end
  end
  always_comb begin
    cdb_d    = (win_valid && !flush) ? {1'b1, head[win]} : '0;
    fu_id_d  = (win_valid && !flush) ? win : '0;
    rr_ptr_d = flush ? '0 : win_valid ? ID_W'((int'(win) + 1) % NUM_FU) : rr_ptr_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_q    <= '0;
      fu_id_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      cdb_q    <= cdb_d;
      fu_id_q  <= fu_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign fu_ready  = ~full;
  assign cdb_valid = cdb_q.valid;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_value = cdb_q.value;
  assign cdb_fu_id = fu_id_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed table, corner sequences and random traffic against a queue-based model
module tb_cdb_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [3:0]   fu_valid;
  logic [23:0]  fu_tag;
  logic [127:0] fu_value;
  logic [3:0]   fu_ready;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_value;
  logic [1:0]   cdb_fu_id;

  cdb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_value  (fu_value),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_fu_id (cdb_fu_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] val;
  } ent_t;

  typedef struct {
    logic [3:0]   v;
    logic [23:0]  tags;
    logic [127:0] vals;
    logic         fl;
    logic         ev;
    logic [5:0]   et;
    logic [31:0]  eval;
    logic [1:0]   eid;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  ent_t        q [4][$];
  int          rr = 0;
  logic        m_v = 1'b0;
  logic [5:0]  m_tag = '0;
  logic [31:0] m_val = '0;
  int          m_id = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = q[i].size() < 2;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) q[i].delete();
    rr = 0; m_v = 1'b0; m_tag = '0; m_val = '0; m_id = 0;
  endtask

  task automatic model_edge();
    logic [3:0] rdy;
    int w;
    ent_t e;
    rdy = m_ready();
    if (flush) begin
      model_clear();
    end else begin
      w = -1;
      for (int j = 0; j < 4; j++)
        if (w < 0 && q[(rr + j) % 4].size() > 0) w = (rr + j) % 4;
      if (w >= 0) begin
        e = q[w].pop_front();
        m_v = 1'b1; m_tag = e.tag; m_val = e.val; m_id = w;
        rr = (w + 1) % 4;
      end else begin
        m_v = 1'b0; m_tag = '0; m_val = '0; m_id = 0;
      end
      for (int i = 0; i < 4; i++)
        if (fu_valid[i] && rdy[i] && fu_tag[i*6 +: 6] != 6'd0)
          q[i].push_back({fu_tag[i*6 +: 6], fu_value[i*32 +: 32]});
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_v));
    chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
    chk("cdb_value", 64'(cdb_value), 64'(m_val));
    chk("cdb_fu_id", 64'(cdb_fu_id), 64'(m_id[1:0]));
    chk("fu_ready", 64'(fu_ready), 64'(m_ready()));
  endtask

  task automatic idle();
    fu_valid = '0; fu_tag = '0; fu_value = '0; flush = 1'b0;
  endtask

  task automatic set_fu(input int i, input logic [5:0] t, input logic [31:0] v);
    fu_valid[i] = 1'b1;
    fu_tag[i*6 +: 6] = t;
    fu_value[i*32 +: 32] = v;
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [23:0] t, input logic [127:0] d,
                              input logic fl, input logic ev, input logic [5:0] et,
                              input logic [31:0] eval, input logic [1:0] eid);
    vec_t r;
    r.v = v; r.tags = t; r.vals = d; r.fl = fl;
    r.ev = ev; r.et = et; r.eval = eval; r.eid = eid;
    return r;
  endfunction

  vec_t tbl [14];

  initial begin
    int  seq [4];
    logic saw_full, saw_rise;
    tbl[0]  = mk(4'b0100, 24'(5) << 12, 128'(32'hDEAD) << 64, 0, 0, 0, 0, 0);
    tbl[1]  = mk(4'b0000, 0, 0, 0, 1, 5, 32'hDEAD, 2);
    tbl[2]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(4'b0000, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},
                 {32'h104, 32'h103, 32'h102, 32'h101}, 0, 0, 0, 0, 0);
    tbl[5]  = mk(4'b0000, 0, 0, 0, 1, 1, 32'h101, 0);
    tbl[6]  = mk(4'b0000, 0, 0, 0, 1, 2, 32'h102, 1);
    tbl[7]  = mk(4'b0000, 0, 0, 0, 1, 3, 32'h103, 2);
    tbl[8]  = mk(4'b0000, 0, 0, 0, 1, 4, 32'h104, 3);
    tbl[9]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(4'b0010, 24'(9) << 6, 128'(32'h99) << 32, 0, 0, 0, 0, 0);
    tbl[11] = mk(4'b0000, 0, 0, 0, 1, 9, 32'h99, 1);
    tbl[12] = mk(4'b1000, 0, 128'(32'h77) << 96, 0, 0, 0, 0, 0);
    tbl[13] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b0;
    idle();
    #12;
    chk("rst_valid", 64'(cdb_valid), 0);
    chk("rst_tag", 64'(cdb_tag), 0);
    chk("rst_value", 64'(cdb_value), 0);
    chk("rst_fu_id", 64'(cdb_fu_id), 0);
    chk("rst_ready", 64'(fu_ready), 64'hF);
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 14; n++) begin
      fu_valid = tbl[n].v; fu_tag = tbl[n].tags; fu_value = tbl[n].vals; flush = tbl[n].fl;
      step();
      chk($sformatf("tbl%0d_valid", n), 64'(cdb_valid), 64'(tbl[n].ev));
      chk($sformatf("tbl%0d_tag", n), 64'(cdb_tag), 64'(tbl[n].et));
      chk($sformatf("tbl%0d_value", n), 64'(cdb_value), 64'(tbl[n].eval));
      chk($sformatf("tbl%0d_id", n), 64'(cdb_fu_id), 64'(tbl[n].eid));
      chk($sformatf("tbl%0d_ready", n), 64'(fu_ready), 64'hF);
    end

    idle(); flush = 1'b1; step(); idle();
    for (int i = 0; i < 4; i++) seq[i] = 0;
    saw_full = 1'b0; saw_rise = 1'b0;
    for (int c = 0; c < 14; c++) begin
      logic [3:0] rdy;
      rdy = m_ready();
      for (int i = 0; i < 4; i++) set_fu(i, 6'(8 * i + 1 + (seq[i] % 7)), 32'(i * 1000 + seq[i]));
      step();
      for (int i = 0; i < 4; i++) if (rdy[i]) seq[i]++;
      if (!fu_ready[0]) saw_full = 1'b1;
      if (saw_full && fu_ready[0]) saw_rise = 1'b1;
    end
    chk("fu0_filled", 64'(saw_full), 1);
    chk("fu0_ready_rises", 64'(saw_rise), 1);
    idle();
    for (int c = 0; c < 10; c++) step();

    idle(); set_fu(3, 6'd0, 32'h5555);
    step();
    chk("x0_ready", 64'(fu_ready[3]), 1);
    idle();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("x0_no_bcast", 64'(cdb_valid), 0);
    end

    idle();
    set_fu(0, 6'd11, 32'hA0); set_fu(1, 6'd12, 32'hA1); set_fu(2, 6'd13, 32'hA2);
    step();
    idle(); flush = 1'b1; set_fu(3, 6'd14, 32'hA3);
    step();
    chk("flush_valid", 64'(cdb_valid), 0);
    idle(); set_fu(2, 6'd7, 32'h700);
    step();
    chk("flush_next_valid", 64'(cdb_valid), 0);
    idle();
    step();
    chk("flush_new_valid", 64'(cdb_valid), 1);
    chk("flush_new_tag", 64'(cdb_tag), 7);
    step();
    chk("flush_quiet", 64'(cdb_valid), 0);

    idle();
    for (int i = 0; i < 4; i++) set_fu(i, 6'(20 + i), 32'(32'hB00 + i));
    step();
    step();
    chk("pre_reset_valid", 64'(cdb_valid), 1);
    idle();
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(cdb_valid), 0);
    chk("midrst_tag", 64'(cdb_tag), 0);
    chk("midrst_value", 64'(cdb_value), 0);
    chk("midrst_id", 64'(cdb_fu_id), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", 64'(fu_ready), 64'hF);
    for (int c = 0; c < 3; c++) step();

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        fu_valid[i] = 1'($urandom_range(0, 1));
        fu_tag[i*6 +: 6] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        fu_value[i*32 +: 32] = $urandom;
      end
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    idle();
    for (int c = 0; c < 10; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
